// File: rtl/bsg_mem_client_pkg.sv
// bsg_mem_client_pkg
//   Shared types and sizing helpers for the bsg_mem_1rw_sync_mask_write_bit
//   client controller and its response FIFO.
//   - client_state_e : controller state (zero-sweep INIT, normal READY)
//   - safe_clog2     : clog2 that never returns 0 (for address/pointer widths)
//   - cnt_width      : width of an occupancy counter holding 0..els inclusive
package bsg_mem_client_pkg;

  typedef enum logic [0:0] {
    e_client_init  = 1'b0,
    e_client_ready = 1'b1
  } client_state_e;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_width(input int els);
    return $clog2(els + 1);
  endfunction

endpackage

// File: rtl/bsg_mem_client_resp_fifo.sv
// bsg_mem_client_resp_fifo
//   In-order response buffer of els_p entries, width_p bits each.
//   Ports:
//     clk_i, reset_n_i   clock, asynchronous active-low reset
//     push_i, data_i     enqueue one entry
//     yumi_i             dequeue the head entry (only when v_o=1)
//     v_o, data_o        head valid / head data (data_o is 0 when empty)
//     count_o            number of stored entries (0..els_p)
//   Simultaneous push and yumi leaves the count unchanged.
module bsg_mem_client_resp_fifo
  import bsg_mem_client_pkg::*;
#(
  parameter int width_p = 8,
  parameter int els_p   = 3
)(
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           push_i,
  input  logic [width_p-1:0]             data_i,
  input  logic                           yumi_i,
  output logic                           v_o,
  output logic [width_p-1:0]             data_o,
  output logic [cnt_width(els_p)-1:0]    count_o
);

  localparam int cnt_w_lp = cnt_width(els_p);
  localparam int ptr_w_lp = safe_clog2(els_p);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] rptr_r, wptr_r;
  logic [cnt_w_lp-1:0] count_r;

  function automatic logic [ptr_w_lp-1:0] ptr_next(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
  endfunction

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rptr_r  <= '0;
      wptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_i) wptr_r <= ptr_next(wptr_r);
      if (yumi_i) rptr_r <= ptr_next(rptr_r);
      unique case ({push_i, yumi_i})
        2'b10:   count_r <= count_r + cnt_w_lp'(1);
        2'b01:   count_r <= count_r - cnt_w_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage needs no reset: data_o is forced to 0 whenever the buffer is empty.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_r[wptr_r] <= data_i;
  end

  assign v_o     = (count_r != '0);
  assign data_o  = v_o ? mem_r[rptr_r] : '0;
  assign count_o = count_r;

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(push_i && !yumi_i && (count_r == cnt_w_lp'(els_p))));
`endif

endmodule

// File: rtl/bsg_mem_1rw_sync_mask_write_bit_client.sv
// bsg_mem_1rw_sync_mask_write_bit_client
//   Initiator-side controller for a single-port synchronous RAM with per-bit
//   write mask. Accepts read / masked-write requests (v_i/ready_o), drives
//   the RAM pins, captures read data one cycle after issue into an in-order
//   response buffer and returns it on v_o/data_o/yumi_i.
//   Ports:
//     clk_i, reset_n_i                      clock, asynchronous active-low reset
//     v_i, ready_o, w_i, addr_i,
//     data_i, w_mask_i                      request channel
//     v_o, data_o, yumi_i                   read response channel
//     mem_v_o, mem_w_o, mem_addr_o,
//     mem_data_o, mem_w_mask_o, mem_data_i  RAM pins
//   Optional feature: define BSG_MEM_CLIENT_INIT_SWEEP_EN to zero every RAM
//   word (els_p cycles, INIT state) after each reset before serving requests.
module bsg_mem_1rw_sync_mask_write_bit_client
  import bsg_mem_client_pkg::*;
#(
  parameter int width_p       = -1,
  parameter int els_p         = -1,
  parameter int addr_width_lp = safe_clog2(els_p),
  parameter int buf_els_p     = 3
)(
  input  logic                     clk_i,
  input  logic                     reset_n_i,

  input  logic                     v_i,
  output logic                     ready_o,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [width_p-1:0]       w_mask_i,

  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     yumi_i,

  output logic                     mem_v_o,
  output logic                     mem_w_o,
  output logic [addr_width_lp-1:0] mem_addr_o,
  output logic [width_p-1:0]       mem_data_o,
  output logic [width_p-1:0]       mem_w_mask_o,
  input  logic [width_p-1:0]       mem_data_i
);

  localparam int cnt_w_lp = cnt_width(buf_els_p);
  localparam int occ_w_lp = cnt_w_lp + 1;

  logic                inflight_r;
  logic [cnt_w_lp-1:0] count;
  logic [occ_w_lp-1:0] occupancy;
  logic                credit_ok;
  logic                in_service;
  logic                xfer;

`ifdef BSG_MEM_CLIENT_INIT_SWEEP_EN
  client_state_e            state_r, state_n;
  logic [addr_width_lp-1:0] sweep_cnt_r;
  logic                     sweep_last;

  assign sweep_last = (sweep_cnt_r == addr_width_lp'(els_p - 1));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= e_client_init;
      sweep_cnt_r <= '0;
    end else begin
      state_r <= state_n;
      if (state_r == e_client_init) sweep_cnt_r <= sweep_cnt_r + addr_width_lp'(1);
    end
  end

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      e_client_init:  if (sweep_last) state_n = e_client_ready;
      e_client_ready: state_n = e_client_ready;
      default:        state_n = e_client_ready;
    endcase
  end

  assign in_service = (state_r == e_client_ready);
`else
  assign in_service = 1'b1;
`endif

  // Credits cover both buffered responses and the read whose data arrives
  // next cycle, so a captured word always has a free slot.
  assign occupancy = {1'b0, count} + {{cnt_w_lp{1'b0}}, inflight_r};
  assign credit_ok = (occupancy < occ_w_lp'(buf_els_p));

  // Gating with reset_n_i keeps ready_o low throughout reset even when the
  // controller would otherwise power up directly in service.
  assign ready_o = reset_n_i & in_service & credit_ok;
  assign xfer    = v_i & ready_o;

  always_comb begin
    mem_v_o      = xfer;
    mem_w_o      = w_i;
    mem_addr_o   = addr_i;
    mem_data_o   = data_i;
    mem_w_mask_o = w_mask_i;
`ifdef BSG_MEM_CLIENT_INIT_SWEEP_EN
    if (reset_n_i && (state_r == e_client_init)) begin
      mem_v_o      = 1'b1;
      mem_w_o      = 1'b1;
      mem_addr_o   = sweep_cnt_r;
      mem_data_o   = '0;
      mem_w_mask_o = '1;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) inflight_r <= 1'b0;
    else            inflight_r <= xfer & ~w_i;
  end

  bsg_mem_client_resp_fifo #(
    .width_p (width_p),
    .els_p   (buf_els_p)
  ) resp_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (inflight_r),
    .data_i    (mem_data_i),
    .yumi_i    (yumi_i),
    .v_o       (v_o),
    .data_o    (data_o),
    .count_o   (count)
  );

`ifndef SYNTHESIS
  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    yumi_i |-> v_o);
  a_addr_in_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    xfer |-> (32'(addr_i) < 32'(els_p)));
`endif

endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_bit_client.sv
module tb_bsg_mem_1rw_sync_mask_write_bit_client;

  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic       v_i, ready_o, w_i;
  logic [3:0] addr_i;
  logic [7:0] data_i, w_mask_i;
  logic       v_o, yumi_i;
  logic [7:0] data_o;
  logic       mem_v_o, mem_w_o;
  logic [3:0] mem_addr_o;
  logic [7:0] mem_data_o, mem_w_mask_o;
  logic [7:0] mem_data_i;

  int total = 0;
  int bad   = 0;

  // Behavioural RAM: masked write, one-cycle read latency. Non-zero power-up
  // contents so a missing sweep is visible.
  logic [7:0] ram [16] = '{default: 8'hEE};

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (mem_v_o) begin
      if (mem_w_o) ram[mem_addr_o] <= (ram[mem_addr_o] & ~mem_w_mask_o) | (mem_data_o & mem_w_mask_o);
      else         mem_data_i <= ram[mem_addr_o];
    end
  end

  bsg_mem_1rw_sync_mask_write_bit_client #(
    .width_p   (8),
    .els_p     (16),
    .buf_els_p (3)
  ) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .v_i          (v_i),
    .ready_o      (ready_o),
    .w_i          (w_i),
    .addr_i       (addr_i),
    .data_i       (data_i),
    .w_mask_i     (w_mask_i),
    .v_o          (v_o),
    .data_o       (data_o),
    .yumi_i       (yumi_i),
    .mem_v_o      (mem_v_o),
    .mem_w_o      (mem_w_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_w_mask_o (mem_w_mask_o),
    .mem_data_i   (mem_data_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic [7:0] m);
    v_i = 1'b1; w_i = 1'b1; addr_i = a; data_i = d; w_mask_i = m;
    #1;
    check("wr_ready", ready_o, 1);
    check("wr_mem_v", mem_v_o, 1);
    check("wr_mem_w", mem_w_o, 1);
    check("wr_mem_mask", mem_w_mask_o, m);
    step();
    v_i = 1'b0; w_i = 1'b0;
  endtask

  task automatic rd_check(input logic [3:0] a, input logic [7:0] exp);
    v_i = 1'b1; w_i = 1'b0; addr_i = a;
    #1;
    check("rd_ready", ready_o, 1);
    check("rd_mem_v", mem_v_o, 1);
    check("rd_mem_w", mem_w_o, 0);
    check("rd_mem_addr", mem_addr_o, a);
    step();
    v_i = 1'b0;
    #1;
    check("rd_v_o_t1", v_o, 0);
    step();
    check("rd_v_o_t2", v_o, 1);
    check("rd_data", data_o, exp);
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
    #1;
    check("rd_v_o_after_yumi", v_o, 0);
  endtask

  initial begin
    int resp;
    v_i = 1'b0; w_i = 1'b0; addr_i = '0; data_i = '0; w_mask_i = '0;
    yumi_i = 1'b0; reset_n_i = 1'b0;

    // Reset state
    #1;
    check("rst_ready", ready_o, 0);
    check("rst_v_o", v_o, 0);
    check("rst_data_o", data_o, 0);
    check("rst_mem_v", mem_v_o, 0);
    step();
    reset_n_i = 1'b1;

`ifdef BSG_MEM_CLIENT_INIT_SWEEP_EN
    // Request offered during the sweep must be held off.
    v_i = 1'b1; addr_i = 4'd9;
    #1;
    for (int i = 0; i < 16; i++) begin
      check("sweep_mem_v", mem_v_o, 1);
      check("sweep_mem_w", mem_w_o, 1);
      check("sweep_addr", mem_addr_o, i);
      check("sweep_data", mem_data_o, 0);
      check("sweep_mask", mem_w_mask_o, 8'hFF);
      check("sweep_ready", ready_o, 0);
      step();
    end
    check("sweep_done_ready", ready_o, 1);
    v_i = 1'b0;
    #1;
    check("idle_mem_v", mem_v_o, 0);
    rd_check(4'd5, 8'h00);
`else
    #1;
    check("first_ready", ready_o, 1);
    check("idle_mem_v", mem_v_o, 0);
`endif

    // Masked write over a known value, then read back
    wr(4'd3, 8'h00, 8'hFF);
    wr(4'd3, 8'hA5, 8'h0F);
    rd_check(4'd3, 8'h05);

    // Back-to-back reads with the consumer always taking
    for (int i = 0; i < 8; i++) wr(i[3:0], 8'h10 + i[7:0], 8'hFF);
    resp = 0;
    for (int c = 0; c < 10; c++) begin
      v_i = (c < 8); w_i = 1'b0; addr_i = c[3:0];
      yumi_i = v_o;
      #1;
      if (c < 8) check("b2b_ready", ready_o, 1);
      check("b2b_v_o", v_o, (c >= 2));
      if (c >= 2) begin
        check("b2b_data", data_o, 8'h10 + resp);
        resp++;
      end
      step();
    end
    v_i = 1'b0; yumi_i = 1'b0;
    #1;
    check("b2b_drained", v_o, 0);

    // Backpressure: 3 credits, 4th read stalls until one yumi
    for (int c = 0; c < 3; c++) begin
      v_i = 1'b1; w_i = 1'b0; addr_i = c[3:0];
      #1;
      check("bp_ready", ready_o, 1);
      step();
    end
    addr_i = 4'd3;
    #1;
    check("bp_stall_ready_c3", ready_o, 0);
    step();
    check("bp_stall_ready_c4", ready_o, 0);
    check("bp_full_v_o", v_o, 1);
    check("bp_head", data_o, 8'h10);
    step();
    yumi_i = 1'b1;
    #1;
    check("bp_stall_ready_c5", ready_o, 0);
    step();
    yumi_i = 1'b0;
    #1;
    check("bp_resume_ready", ready_o, 1);
    check("bp_resume_mem_v", mem_v_o, 1);
    check("bp_resume_addr", mem_addr_o, 3);
    step();
    v_i = 1'b0;
    step();
    for (int j = 1; j < 4; j++) begin
      check("bp_order_v", v_o, 1);
      check("bp_order_data", data_o, 8'h10 + j);
      yumi_i = 1'b1;
      step();
    end
    yumi_i = 1'b0;
    #1;
    check("bp_drained", v_o, 0);

    // Reset with one read in flight and two buffered responses
    for (int c = 4; c < 7; c++) begin
      v_i = 1'b1; w_i = 1'b0; addr_i = c[3:0];
      step();
    end
    v_i = 1'b0;
    #1;
    check("mid_v_o", v_o, 1);
    check("mid_head", data_o, 8'h14);
    reset_n_i = 1'b0;
    #1;
    check("mid_rst_v_o", v_o, 0);
    check("mid_rst_ready", ready_o, 0);
    check("mid_rst_data", data_o, 0);
    check("mid_rst_mem_v", mem_v_o, 0);
    step();
    step();
    reset_n_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      check("post_rst_no_v_o", v_o, 0);
      step();
    end
    check("post_rst_ready", ready_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
